// File: rtl/adc_capture_ctrl.sv
// Capture sequencer between the host register block and the ADC FIFO writer.
// Optional ARMED timeout / forced trigger is enabled by defining CAPTURE_TIMEOUT_EN.
module adc_capture_ctrl #(
  parameter int unsigned OFFSET_W = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                adc_sampleclk,
  input  logic                reset_n,
  input  logic                arm_i,
  input  logic                abort_i,
  input  logic                trig_in,
  input  logic                trig_pol_i,
  input  logic                trig_mode_i,
  input  logic [OFFSET_W-1:0] trig_offset_i,
  input  logic                adc_capture_stop,
`ifdef CAPTURE_TIMEOUT_EN
  input  logic [31:0]         timeout_i,
  output logic                timed_out_o,
`endif
  output logic                adc_capture_go,
  output logic                adc_trig_status,
  output logic                armed_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    capture_cnt_o
);

  typedef enum logic [2:0] {StIdle, StArmed, StDelay, StCapture, StDone} state_e;

  state_e              state_q, state_d;
  logic                prev_act_q;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [1:0]          cap_cyc_q;
  logic                act, trig_hit, force_trig, fire, cnt_inc;
  logic                go_d, ts_d, armed_d, done_d;

  assign act      = (trig_in == trig_pol_i);
  assign trig_hit = trig_mode_i ? (act && !prev_act_q) : act;

`ifdef CAPTURE_TIMEOUT_EN
  logic [31:0] to_cnt_q;

  // Forces a trigger on the timeout_i-th consecutive ARMED cycle.
  assign force_trig = (state_q == StArmed) && (timeout_i != 32'd0) &&
                      (to_cnt_q + 32'd1 == timeout_i);

  always_ff @(posedge adc_sampleclk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q    <= 32'd0;
      timed_out_o <= 1'b0;
    end else begin
      to_cnt_q <= (state_q == StArmed) ? to_cnt_q + 32'd1 : 32'd0;
      if (abort_i) begin
        timed_out_o <= 1'b0;
      end else if (force_trig) begin
        timed_out_o <= 1'b1;
      end else if (arm_i) begin
        timed_out_o <= 1'b0;
      end
    end
  end
`else
  assign force_trig = 1'b0;
`endif

  assign fire = trig_hit || force_trig;

  always_ff @(posedge adc_sampleclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      prev_act_q      <= 1'b0;
      offset_q        <= '0;
      cap_cyc_q       <= 2'd0;
      capture_cnt_o   <= '0;
      adc_capture_go  <= 1'b0;
      adc_trig_status <= 1'b0;
      armed_o         <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      // Preloading "active" on ARMED entry blocks an edge from an already-asserted trigger.
      prev_act_q <= (state_q != StArmed && state_d == StArmed) ? 1'b1 : act;
      if (state_q != StCapture) begin
        cap_cyc_q <= 2'd0;
      end else if (cap_cyc_q != 2'd2) begin
        cap_cyc_q <= cap_cyc_q + 2'd1;
      end
      if (cnt_inc) begin
        capture_cnt_o <= capture_cnt_o + CNT_W'(1);
      end
      adc_capture_go  <= go_d;
      adc_trig_status <= ts_d;
      armed_o         <= armed_d;
      done_o          <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    cnt_inc  = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (arm_i) state_d = StArmed;
        end
        StArmed: begin
          if (fire) begin
            if (trig_offset_i == '0) begin
              state_d = StCapture;
            end else begin
              state_d  = StDelay;
              offset_d = trig_offset_i;
            end
          end
        end
        StDelay: begin
          offset_d = offset_q - OFFSET_W'(1);
          if (offset_q <= OFFSET_W'(1)) state_d = StCapture;
        end
        StCapture: begin
          // The writer's stop flag can lag go by two cycles, so early stops are stale.
          if (adc_capture_stop && cap_cyc_q == 2'd2) begin
            state_d = StDone;
            cnt_inc = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    go_d    = (state_d == StCapture);
    ts_d    = (state_d == StDelay) || (state_d == StCapture);
    armed_d = (state_d == StArmed);
    done_d  = (state_d == StDone);
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Table-driven bench for adc_capture_ctrl: one vector per clock, plus an async reset sequence.
module tb_adc_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        arm_i = 1'b0, abort_i = 1'b0, trig_in = 1'b0;
  logic        trig_pol_i = 1'b1, trig_mode_i = 1'b0, adc_capture_stop = 1'b0;
  logic [31:0] trig_offset_i = 32'd0;
  logic        adc_capture_go, adc_trig_status, armed_o, done_o;
  logic [15:0] capture_cnt_o;
`ifdef CAPTURE_TIMEOUT_EN
  logic [31:0] timeout_i = 32'd0;
  logic        timed_out_o;
`endif

  always #5 clk = ~clk;

  adc_capture_ctrl #(.OFFSET_W(32), .CNT_W(16)) dut (
    .adc_sampleclk    (clk),
    .reset_n          (reset_n),
    .arm_i            (arm_i),
    .abort_i          (abort_i),
    .trig_in          (trig_in),
    .trig_pol_i       (trig_pol_i),
    .trig_mode_i      (trig_mode_i),
    .trig_offset_i    (trig_offset_i),
    .adc_capture_stop (adc_capture_stop),
`ifdef CAPTURE_TIMEOUT_EN
    .timeout_i        (timeout_i),
    .timed_out_o      (timed_out_o),
`endif
    .adc_capture_go   (adc_capture_go),
    .adc_trig_status  (adc_trig_status),
    .armed_o          (armed_o),
    .done_o           (done_o),
    .capture_cnt_o    (capture_cnt_o)
  );

  typedef struct {
    logic        arm, abort, trig, pol, mode;
    logic [31:0] off;
    logic        stop;
    logic        go, ts, armed, done;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic void add(logic arm, logic abort, logic trig, logic pol, logic mode,
                              logic [31:0] off, logic stop, logic go, logic ts,
                              logic armed, logic done, logic [15:0] cnt);
    vec_t v;
    v.arm = arm; v.abort = abort; v.trig = trig; v.pol = pol; v.mode = mode;
    v.off = off; v.stop = stop; v.go = go; v.ts = ts; v.armed = armed; v.done = done;
    v.cnt = cnt;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s[%0d] got %0h want %0h", name, idx, got, want);
    end
  endtask

  task automatic chk_all(input int idx, input logic go, input logic ts, input logic armed,
                         input logic done, input logic [15:0] cnt);
    chk("go", idx, {31'd0, adc_capture_go}, {31'd0, go});
    chk("trig_status", idx, {31'd0, adc_trig_status}, {31'd0, ts});
    chk("armed", idx, {31'd0, armed_o}, {31'd0, armed});
    chk("done", idx, {31'd0, done_o}, {31'd0, done});
    chk("cnt", idx, {16'd0, capture_cnt_o}, {16'd0, cnt});
  endtask

  initial begin
    //  arm ab trg pol md off stp | go ts arm dn cnt
    add(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0);  // 0 idle
    add(1, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0);  // 1 arm
    add(0, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 0);
    add(0, 0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0);  // 3 level fire, offset 0
    add(0, 0, 1, 1, 0, 0, 1,  1, 1, 0, 0, 0);  // 4-5 stale stop ignored
    add(0, 0, 1, 1, 0, 0, 1,  1, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, 1,  0, 0, 0, 1, 1);  // 6 done at entry+3
    add(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 1);
    add(1, 0, 1, 1, 1, 0, 0,  0, 0, 1, 0, 1);  // 8 edge mode, trig already high
    add(0, 0, 1, 1, 1, 0, 0,  0, 0, 1, 0, 1);  // 9 no fire
    add(0, 0, 0, 1, 1, 0, 0,  0, 0, 1, 0, 1);
    add(0, 0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 1);  // 11 rising edge fires
    add(0, 0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 1, 0, 1,  0, 0, 0, 1, 2);
    add(1, 0, 0, 1, 0, 3, 0,  0, 0, 1, 0, 2);  // 15 rearm from DONE
    add(0, 0, 1, 1, 0, 3, 0,  0, 1, 0, 0, 2);  // 16 fire with offset 3
    add(0, 0, 0, 1, 0, 0, 0,  0, 1, 0, 0, 2);  // 17-18 offset changes ignored
    add(0, 0, 0, 1, 0, 7, 0,  0, 1, 0, 0, 2);
    add(0, 0, 0, 1, 0, 7, 0,  1, 1, 0, 0, 2);  // 19 go after 3 delay cycles
    add(0, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 2);  // 20 abort in CAPTURE
    add(1, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 2);
    add(1, 0, 0, 1, 0, 0, 0,  0, 0, 1, 0, 2);  // 22 arm in ARMED ignored
    add(0, 0, 1, 1, 0, 2, 0,  0, 1, 0, 0, 2);
    add(0, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 2);  // 24 abort in DELAY
    add(0, 0, 1, 1, 0, 0, 0,  0, 0, 0, 0, 2);
    add(1, 0, 1, 1, 0, 0, 0,  0, 0, 1, 0, 2);
    add(0, 0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 2);
    add(0, 1, 1, 1, 0, 0, 1,  0, 0, 0, 0, 2);  // 28 abort beats stop
    add(1, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 2);  // 29 abort beats arm
    add(0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 2);
    add(1, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 2);  // 31 active-low polarity
    add(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1, 3);
    add(1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 3);  // 37 in CAPTURE for reset test

    repeat (3) @(posedge clk);
    #1 chk_all(-1, 0, 0, 0, 0, 16'd0);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      arm_i = vecs[i].arm; abort_i = vecs[i].abort; trig_in = vecs[i].trig;
      trig_pol_i = vecs[i].pol; trig_mode_i = vecs[i].mode;
      trig_offset_i = vecs[i].off; adc_capture_stop = vecs[i].stop;
      @(posedge clk);
      #1 chk_all(i, vecs[i].go, vecs[i].ts, vecs[i].armed, vecs[i].done, vecs[i].cnt);
    end

    // Asynchronous reset mid-CAPTURE, away from any clock edge.
    #2 reset_n = 1'b0;
    #1 chk_all(100, 0, 0, 0, 0, 16'd0);
    @(negedge clk);
    reset_n = 1'b1; arm_i = 1'b0; trig_in = 1'b1; trig_pol_i = 1'b0;
    @(posedge clk);
    #1 chk_all(101, 0, 0, 0, 0, 16'd0);
    @(negedge clk) arm_i = 1'b1;
    @(posedge clk);
    #1 chk_all(102, 0, 0, 1, 0, 16'd0);
    @(negedge clk) arm_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Capture sequencer for the ADC sample FIFO path. It arms on request, waits for a qualified trigger, applies an optional post-trigger sample delay, and then drives the FIFO writer's `adc_capture_go`. It holds `adc_capture_go` until the writer returns `adc_capture_stop`, then reports completion. It sits between the host register block and the ADC FIFO writer, entirely in the ADC sample clock domain.

## Interface
- `OFFSET_W`, 32: width of the trigger offset counter.
- `CNT_W`, 16: width of the completed-capture counter.

- `adc_sampleclk`  in  1: sample clock; the only clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `arm_i`  in  1: single-cycle arm request.
- `abort_i`  in  1: level; returns to IDLE.
- `trig_in`  in  1: raw trigger, already synchronous to `adc_sampleclk`.
- `trig_pol_i`  in  1: 1 = active-high/rising, 0 = active-low/falling.
- `trig_mode_i`  in  1: 0 = level, 1 = edge.
- `trig_offset_i`  in  OFFSET_W: samples between trigger and capture start.
- `adc_capture_stop`  in  1: stop from the FIFO writer.
- `adc_capture_go`  out  1: capture enable to the FIFO writer.
- `adc_trig_status`  out  1: triggered flag, muxed into FIFO word bit 30.
- `armed_o`  out  1: high in ARMED.
- `done_o`  out  1: high in DONE.
- `capture_cnt_o`  out  CNT_W: completed captures, wraps.

## Operation
- States: IDLE, ARMED, DELAY, CAPTURE, DONE. All outputs are registered.
- Reset values: state IDLE, all 1-bit outputs 0, `capture_cnt_o` 0, offset counter 0.
- Trigger qualification, with `act = (trig_in == trig_pol_i)`:
  - Level mode fires when `act` is true.
  - Edge mode fires when `act` is true and the previous sample was not active.
  - On ARMED entry the previous-sample register is loaded with "active". An already-asserted trigger therefore cannot fire an edge on the first ARMED cycle.
- Transitions:
  - IDLE or DONE, with `arm_i` → ARMED. `arm_i` in any other state is ignored.
  - ARMED, trigger fires and `trig_offset_i` == 0 → CAPTURE.
  - ARMED, trigger fires and offset != 0 → DELAY. The offset is latched at the fire cycle; later `trig_offset_i` changes are ignored.
  - DELAY: count down from the latched offset; at the count reaching 1 → CAPTURE.
  - CAPTURE, with `adc_capture_stop` sampled high → DONE.
    - `adc_capture_stop` is ignored in the first 2 CAPTURE cycles, because the writer's stop flag lags `adc_capture_go` by up to 2 cycles.
    - `capture_cnt_o` increments on the CAPTURE→DONE transition; it wraps from all-ones to 0.
  - DONE holds until `arm_i` or `abort_i`.
  - `abort_i` high in any state → IDLE next cycle. Abort has priority over `arm_i`, trigger and stop.
- Outputs per state:
  - `adc_capture_go` = 1 only in CAPTURE.
  - `adc_trig_status` = 1 in DELAY and CAPTURE.
  - `armed_o` = 1 in ARMED.
  - `done_o` = 1 in DONE.
- Aborting out of CAPTURE drops `adc_capture_go` and does not increment `capture_cnt_o`.

## Timing
- `arm_i` at cycle n → `armed_o` = 1 at n+1.
- Trigger fire sampled at cycle m, offset 0 → `adc_capture_go` and `adc_trig_status` = 1 at m+1.
- Offset k > 0 → `adc_trig_status` = 1 at m+1; `adc_capture_go` = 1 at m+1+k.
- `adc_capture_stop` sampled at cycle s, with s ≥ CAPTURE entry + 2 → at s+1: `adc_capture_go` = 0, `done_o` = 1, and the counter is incremented.
- Minimum CAPTURE length is 3 cycles.
- `reset_n` low at any time clears all state and outputs immediately (asynchronous). Release is sampled at the next `adc_sampleclk` edge.

## Configuration
- `CAPTURE_TIMEOUT_EN` defined:
  - Adds input `timeout_i` [31:0] and output `timed_out_o` (reset value 0).
  - A counter runs while in ARMED. When it reaches `timeout_i` (only when `timeout_i` != 0), the controller force-triggers as if the trigger had fired and sets `timed_out_o`.
  - `timed_out_o` stays set until the next `arm_i` or `abort_i`.
- `CAPTURE_TIMEOUT_EN` undefined: ports absent; ARMED waits indefinitely.

## Test plan
- Level trigger, high polarity, offset 0: arm at cycle 10, `trig_in` high at cycle 20 → `adc_capture_go` high from cycle 21; stop at cycle 40 → `adc_capture_go` low and `done_o` high at cycle 41; `capture_cnt_o` = 1.
- Edge mode with `trig_in` already high when armed → no fire. Drive low, then high at cycle 30 → `adc_capture_go` at cycle 31.
- Offset 5, trigger fire at cycle 50 → `adc_trig_status` at 51, `adc_capture_go` at 56. Change `trig_offset_i` during DELAY → no effect.
- Stale stop: `adc_capture_stop` held high entering CAPTURE → ignored for 2 cycles; DONE at CAPTURE entry + 3.
- `abort_i` during DELAY and during CAPTURE → IDLE next cycle, go low, counter unchanged. `arm_i` pulsed in ARMED → ignored. `reset_n` low mid-CAPTURE → all outputs 0 immediately.
- With `CAPTURE_TIMEOUT_EN`, `timeout_i` = 100 and no trigger → forced capture starts about 100 cycles after ARMED, with `timed_out_o` = 1.
- With `CAPTURE_TIMEOUT_EN` and `timeout_i` = 0 → no forced capture.
